// File: rtl/alu_mul_sequencer_pkg.sv
// Shared constants, state encoding and helpers for the shift-and-add multiply sequencer.
// The ALU control codes mirror the fullALU select encodings used by the core.
package alu_mul_sequencer_pkg;

    localparam int unsigned MSEQ_W = 16;

    localparam logic [3:0] ALU_OPX_ADD   = 4'd1;
    localparam logic [2:0] ALUA_SRCX_SEQ = 3'd6;
    localparam logic [2:0] ALUB_SRCX_SEQ = 3'd6;

    typedef enum logic [2:0] {
        MSEQ_IDLE  = 3'd0,
        MSEQ_ADD   = 3'd1,
        MSEQ_SHIFT = 3'd2,
        MSEQ_DONE  = 3'd3
    } mseq_state_e;

    // Partial-product addend: the multiplicand when the current multiplier bit is set.
    function automatic logic [MSEQ_W-1:0] mseq_addend(input logic lsb, input logic [MSEQ_W-1:0] mcand);
        mseq_addend = lsb ? mcand : 16'h0000;
    endfunction

endpackage

// File: rtl/alu_mul_sequencer_if.sv
// Core <-> multiply sequencer bundle, including the borrowed fullALU result/flag path.
// master = core/ALU side, slave = sequencer.
interface alu_mul_sequencer_if;
    import alu_mul_sequencer_pkg::*;

    logic              START;
    logic [15:0]       OPA;
    logic [15:0]       OPB;
    logic [15:0]       ALU_R;
    logic              CC_CARRY;
    logic              OWN;
    logic [3:0]        ALU_OPX;
    logic [2:0]        ALUA_SRCX;
    logic [2:0]        ALUB_SRCX;
    logic [15:0]       SEQ_A;
    logic [15:0]       SEQ_B;
    logic              CCL_LD;
    logic              BUSY;
    logic              DONE;
    logic [15:0]       PROD_HI;
    logic [15:0]       PROD_LO;

    modport master (
        output START, OPA, OPB, ALU_R, CC_CARRY,
        input  OWN, ALU_OPX, ALUA_SRCX, ALUB_SRCX, SEQ_A, SEQ_B,
               CCL_LD, BUSY, DONE, PROD_HI, PROD_LO
    );

    modport slave (
        input  START, OPA, OPB, ALU_R, CC_CARRY,
        output OWN, ALU_OPX, ALUA_SRCX, ALUB_SRCX, SEQ_A, SEQ_B,
               CCL_LD, BUSY, DONE, PROD_HI, PROD_LO
    );

endinterface

// File: rtl/alu_mul_sequencer.sv
// Unsigned 16x16->32 multiply via 16 ADD/SHIFT iterations on the shared fullALU.
// Fixed 34-cycle latency from accepted START back to IDLE.
module alu_mul_sequencer
    import alu_mul_sequencer_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RESET_N,
    alu_mul_sequencer_if.slave   bus
);

    mseq_state_e  state_q, state_d;
    logic [15:0]  mcand_q, mcand_d;
    logic [15:0]  p_hi_q,  p_hi_d;
    logic [15:0]  p_lo_q,  p_lo_d;
    logic [15:0]  sum_q,   sum_d;
    logic [3:0]   cnt_q,   cnt_d;

    logic         own_s;
    logic         add_s;

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= MSEQ_IDLE;
            mcand_q <= 16'h0000;
            p_hi_q  <= 16'h0000;
            p_lo_q  <= 16'h0000;
            sum_q   <= 16'h0000;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            p_hi_q  <= p_hi_d;
            p_lo_q  <= p_lo_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and datapath update for the shift-and-add loop.
    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        p_hi_d  = p_hi_q;
        p_lo_d  = p_lo_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        case (state_q)
            MSEQ_IDLE: begin
                if (bus.START) begin
                    mcand_d = bus.OPA;
                    p_lo_d  = bus.OPB;
                    p_hi_d  = 16'h0000;
                    cnt_d   = 4'd0;
                    state_d = MSEQ_ADD;
                end else begin
                    state_d = MSEQ_IDLE;
                end
            end
            MSEQ_ADD: begin
                sum_d   = bus.ALU_R;
                state_d = MSEQ_SHIFT;
            end
            MSEQ_SHIFT: begin
                // The carry of this iteration's add becomes the new top bit.
                p_hi_d = {bus.CC_CARRY, sum_q[15:1]};
                p_lo_d = {sum_q[0], p_lo_q[15:1]};
                if (cnt_q == 4'd15) begin
                    state_d = MSEQ_DONE;
                end else begin
                    cnt_d   = cnt_q + 4'd1;
                    state_d = MSEQ_ADD;
                end
            end
            MSEQ_DONE: begin
                state_d = MSEQ_IDLE;
            end
            default: begin
                state_d = MSEQ_IDLE;
            end
        endcase
    end

    // Output decode from the registered state.
    always_comb begin
        own_s = 1'b0;
        add_s = 1'b0;
        case (state_q)
            MSEQ_ADD: begin
                own_s = 1'b1;
                add_s = 1'b1;
            end
            MSEQ_SHIFT: begin
                own_s = 1'b1;
                add_s = 1'b0;
            end
            default: begin
                own_s = 1'b0;
                add_s = 1'b0;
            end
        endcase
    end

    assign bus.OWN       = own_s;
    assign bus.BUSY      = own_s;
    assign bus.CCL_LD    = add_s;
    assign bus.DONE      = (state_q == MSEQ_DONE);
    assign bus.ALU_OPX   = own_s ? ALU_OPX_ADD   : 4'd0;
    assign bus.ALUA_SRCX = own_s ? ALUA_SRCX_SEQ : 3'd0;
    assign bus.ALUB_SRCX = own_s ? ALUB_SRCX_SEQ : 3'd0;
    assign bus.SEQ_A     = add_s ? p_hi_q : 16'h0000;
    assign bus.SEQ_B     = add_s ? mseq_addend(p_lo_q[0], mcand_q) : 16'h0000;
    assign bus.PROD_HI   = p_hi_q;
    assign bus.PROD_LO   = p_lo_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer with a behavioural fullALU (adder + latched carry).
module tb_alu_mul_sequencer;
    import alu_mul_sequencer_pkg::*;

    logic CLK;
    logic RESET_N;
    logic cc_q;
    logic [16:0] alu_wide_s;
    int   tests;
    int   fails;

    alu_mul_sequencer_if bus_if ();

    alu_mul_sequencer u_dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus_if)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    assign alu_wide_s     = {1'b0, bus_if.SEQ_A} + {1'b0, bus_if.SEQ_B};
    assign bus_if.ALU_R   = alu_wide_s[15:0];
    assign bus_if.CC_CARRY = cc_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) cc_q <= 1'b0;
        else if (bus_if.CCL_LD) cc_q <= alu_wide_s[16];
        else cc_q <= cc_q;
    end

    function automatic logic [79:0] all_outs();
        all_outs = {2'b00, bus_if.OWN, bus_if.ALU_OPX, bus_if.ALUA_SRCX, bus_if.ALUB_SRCX,
                    bus_if.SEQ_A, bus_if.SEQ_B, bus_if.CCL_LD, bus_if.BUSY, bus_if.DONE,
                    bus_if.PROD_HI, bus_if.PROD_LO};
    endfunction

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one operation and gathers per-cycle observations (cycle 1 = first cycle after acceptance).
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input int restart_a, input int restart_b, input int reset_cyc,
                          output int done_cyc, output int busy_n, output int ccl_n,
                          output int carry_seen, output int seqb_nz, output int ctl_bad,
                          output logic [31:0] prod);
        done_cyc = 0; busy_n = 0; ccl_n = 0; carry_seen = 0; seqb_nz = 0; ctl_bad = 0;
        prod = 32'h0;
        @(negedge CLK);
        bus_if.START = 1'b1; bus_if.OPA = a; bus_if.OPB = b;
        @(posedge CLK); #1;
        bus_if.START = 1'b0; bus_if.OPA = ~a; bus_if.OPB = ~b;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (cyc == restart_a || cyc == restart_b) begin
                bus_if.START = 1'b1; bus_if.OPA = 16'hAAAA; bus_if.OPB = 16'h5555;
            end else begin
                bus_if.START = 1'b0;
            end
            if (cyc == reset_cyc) begin
                RESET_N = 1'b0;
                #1;
                check("async_reset_outs", all_outs(), 80'h0);
                @(negedge CLK);
                @(negedge CLK);
                RESET_N = 1'b1;
            end
            if (bus_if.BUSY) busy_n++;
            if (bus_if.CCL_LD) ccl_n++;
            if (bus_if.DONE && done_cyc == 0) begin
                done_cyc = cyc;
                prod = {bus_if.PROD_HI, bus_if.PROD_LO};
            end
            if (bus_if.OWN && !bus_if.CCL_LD && bus_if.CC_CARRY) carry_seen = 1;
            if (bus_if.CCL_LD && bus_if.SEQ_B != 16'h0000) seqb_nz++;
            if (bus_if.OWN !== bus_if.BUSY) ctl_bad++;
            if (bus_if.OWN && (bus_if.ALU_OPX !== ALU_OPX_ADD || bus_if.ALUA_SRCX !== ALUA_SRCX_SEQ
                               || bus_if.ALUB_SRCX !== ALUB_SRCX_SEQ)) ctl_bad++;
            if (!bus_if.OWN && (bus_if.ALU_OPX !== 4'd0 || bus_if.ALUA_SRCX !== 3'd0
                                || bus_if.ALUB_SRCX !== 3'd0)) ctl_bad++;
            if (!bus_if.CCL_LD && (bus_if.SEQ_A !== 16'h0000 || bus_if.SEQ_B !== 16'h0000)) ctl_bad++;
            @(posedge CLK); #1;
        end
        bus_if.START = 1'b0;
    endtask

    int          d_cyc, b_n, c_n, cy, sb, cb;
    logic [31:0] pr;

    initial begin
        tests = 0; fails = 0;
        RESET_N = 1'b0;
        bus_if.START = 1'b1; bus_if.OPA = 16'h1234; bus_if.OPB = 16'h4321;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_outs", all_outs(), 80'h0);
        @(negedge CLK);
        bus_if.START = 1'b0;
        RESET_N = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check("idle_after_release", all_outs(), 80'h0);

        // 0x1234 * 0x4321 = 0x04C5F4B4
        run_op(16'h1234, 16'h4321, 0, 0, 0, d_cyc, b_n, c_n, cy, sb, cb, pr);
        check("op1_done_cycle", 80'(d_cyc), 80'd33);
        check("op1_product", 80'(pr), 80'h04C5F4B4);
        check("op1_busy_cycles", 80'(b_n), 80'd32);
        check("op1_ccl_cycles", 80'(c_n), 80'd16);
        check("op1_ctl", 80'(cb), 80'd0);
        check("op1_prod_held", 80'({bus_if.PROD_HI, bus_if.PROD_LO}), 80'h04C5F4B4);

        // 0xFFFF * 0xFFFF = 0xFFFE0001, carry must propagate
        run_op(16'hFFFF, 16'hFFFF, 0, 0, 0, d_cyc, b_n, c_n, cy, sb, cb, pr);
        check("op2_done_cycle", 80'(d_cyc), 80'd33);
        check("op2_product", 80'(pr), 80'hFFFE0001);
        check("op2_carry_seen", 80'(cy), 80'd1);
        check("op2_ctl", 80'(cb), 80'd0);

        // 0xFFFF * 0x0000 = 0, addend always zero
        run_op(16'hFFFF, 16'h0000, 0, 0, 0, d_cyc, b_n, c_n, cy, sb, cb, pr);
        check("op3_done_cycle", 80'(d_cyc), 80'd33);
        check("op3_product", 80'(pr), 80'h0);
        check("op3_seqb_zero", 80'(sb), 80'd0);
        check("op3_busy_cycles", 80'(b_n), 80'd32);

        // 0x00FF * 0x0101 = 0x0000FFFF; START in cycle 10 and in DONE is ignored
        run_op(16'h00FF, 16'h0101, 10, 33, 0, d_cyc, b_n, c_n, cy, sb, cb, pr);
        check("op4_done_cycle", 80'(d_cyc), 80'd33);
        check("op4_product", 80'(pr), 80'h0000FFFF);
        check("op4_busy_cycles", 80'(b_n), 80'd32);
        check("op4_no_restart", 80'(bus_if.BUSY), 80'd0);
        check("op4_prod_held", 80'({bus_if.PROD_HI, bus_if.PROD_LO}), 80'h0000FFFF);

        // Reset in cycle 15 aborts with no DONE
        run_op(16'h1234, 16'h4321, 0, 0, 15, d_cyc, b_n, c_n, cy, sb, cb, pr);
        check("op5_no_done", 80'(d_cyc), 80'd0);
        check("op5_idle_outs", all_outs(), 80'h0);

        // 0x8003 * 0x0005 = 0x0002800F after the abort
        run_op(16'h8003, 16'h0005, 0, 0, 0, d_cyc, b_n, c_n, cy, sb, cb, pr);
        check("op6_done_cycle", 80'(d_cyc), 80'd33);
        check("op6_product", 80'(pr), 80'h0002800F);
        check("op6_ccl_cycles", 80'(c_n), 80'd16);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_mul_sequencer.md
# alu_mul_sequencer

Multi-cycle sequencer that computes an unsigned 16x16→32 multiply by driving the shared fullALU through a fixed shift-and-add loop. It sits beside the execute stage. While busy, it owns the ALU operation select, source selects and condition-code latch strobe. It returns a 32-bit product to the core. Latency is fixed at 34 cycles regardless of operands.

## Interface
- No parameters; width fixed at 16.
- CLK  in  1  system clock; all state updates on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- START  in  1  request; sampled only in IDLE.
- OPA  in  16  multiplicand; captured on accepted START.
- OPB  in  16  multiplier; captured on accepted START.
- ALU_R  in  16  fullALU result (combinational from SEQ_A/SEQ_B).
- CC_CARRY  in  1  fullALU latched carry flag.
- OWN  out  1  high while the sequencer drives the ALU controls; core muxes on this.
- ALU_OPX  out  4  ALU operation; `ALU_OPX_ADD when OWN, else 0.
- ALUA_SRCX  out  3  `ALUA_SRCX_SEQ when OWN, else 0.
- ALUB_SRCX  out  3  `ALUB_SRCX_SEQ when OWN, else 0.
- SEQ_A  out  16  ALU A operand (P_HI).
- SEQ_B  out  16  ALU B operand (MCAND or 0).
- CCL_LD  out  1  condition-code latch strobe.
- BUSY  out  1  operation in progress.
- DONE  out  1  one-cycle completion pulse.
- PROD_HI  out  16  product bits 31:16.
- PROD_LO  out  16  product bits 15:0.

## Operation
- Internal registers: MCAND[15:0], P_HI[15:0], P_LO[15:0], SUM[15:0], CNT[3:0], 3-bit state.
- IDLE: if START, then MCAND←OPA, P_LO←OPB, P_HI←0, CNT←0, go to ADD. Otherwise hold. PROD_* keep the last result.
- ADD:
  - OWN=1, CCL_LD=1.
  - SEQ_A=P_HI; SEQ_B=P_LO[0] ? MCAND : 16'h0000.
  - SUM←ALU_R. Go to SHIFT.
- SHIFT:
  - OWN=1, CCL_LD=0.
  - P_HI←{CC_CARRY, SUM[15:1]}; P_LO←{SUM[0], P_LO[15:1]}.
  - If CNT==15, go to DONE; else CNT←CNT+1 and go to ADD.
- DONE: DONE=1, OWN=0. PROD_HI=P_HI, PROD_LO=P_LO. Go to IDLE.
- PROD_HI/PROD_LO always reflect P_HI/P_LO. They are valid from the DONE cycle until the next accepted START.
- Architectural CC flags after completion reflect the last ADD iteration and are not defined as the product's flags. The core reloads CC if required.
- SEQ_A/SEQ_B are 0 outside ADD.

## Timing
- Reset (asynchronous, RESET_N=0): state IDLE; all registers 0; every output 0.
- START accepted at edge 0:
  - ADD in cycles 1,3,…,31; SHIFT in cycles 2,4,…,32.
  - DONE high in cycle 33; IDLE from cycle 34.
- BUSY=1 and OWN=1 in cycles 1–32. BUSY=0 in DONE.
- Earliest next START accepted at the edge ending cycle 34 (IDLE). START during BUSY or DONE is ignored and not queued.
- CCL_LD high exactly one cycle per ADD, so CC_CARRY read in SHIFT is the carry of that ADD's sum.
- A RESET_N assertion mid-operation aborts immediately to IDLE with zeroed outputs. No DONE is issued.
- Operand changes on OPA/OPB after acceptance have no effect.

## Structure
- Add to constants.v: `ALUA_SRCX_SEQ and `ALUB_SRCX_SEQ (fullALU source select codes for the sequencer operand ports), plus the state encodings `MSEQ_IDLE, `MSEQ_ADD, `MSEQ_SHIFT, `MSEQ_DONE.
- `ALU_OPX_ADD is reused from constants.v.
- Single module. fullALU is not instantiated inside; the bench and core instantiate it alongside and wire SEQ_A/SEQ_B into its sequencer source inputs.

## Test plan
- Reset: hold RESET_N=0 with START=1 → all outputs 0. Release → no activity until START is sampled in IDLE.
- OPA=16'h1234, OPB=16'h4321 → DONE in cycle 33; PROD_HI=16'h04C5, PROD_LO=16'hF4B4; BUSY high for exactly 32 cycles; CCL_LD high on 16 cycles.
- OPA=16'hFFFF, OPB=16'hFFFF → PROD_HI=16'hFFFE, PROD_LO=16'h0001. Carry path is exercised (CC_CARRY=1 seen in SHIFT).
- OPB=16'h0000, OPA=16'hFFFF → product 0, still DONE in cycle 33. SEQ_B=0 in every ADD.
- START pulsed again in cycle 10 with different operands → ignored. Result equals the first operation.
- RESET_N low in cycle 15 → asynchronous return to IDLE, outputs 0, no DONE. A new START after release completes correctly.
